// File: rtl/arbiter_1_to_n_request_multicast_pkg.sv
// Shared types and constants for the 1-to-N multicast request arbiter.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package arbiter_1_to_n_request_multicast_pkg;

    // Drop counter width and its saturation value.
    localparam int              DROP_COUNT_WIDTH = 32;
    localparam logic [31:0]     DROP_COUNT_MAX   = 32'hFFFF_FFFF;

    // Post-reset setup sequencing: HOLD and WAIT keep the setup flag high.
    typedef enum logic [1:0] {
        SETUP_HOLD = 2'd0,
        SETUP_WAIT = 2'd1,
        SETUP_DONE = 2'd2
    } setup_state_t;

    // Occupancy counters need one extra bit so that "full" (== depth) is representable.
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/arbiter_1_to_n_request_multicast_fifo_sync_fwft.sv
// Synchronous circular-buffer FIFO with first-word fall-through head and simultaneous push/pop.
// Latency: a push at edge k is visible on head_dat from cycle k when the FIFO was empty.
// Backpressure: push_rdy drops when full unless a pop is taken in the same cycle.
module fifo_sync_fwft
    import arbiter_1_to_n_request_multicast_pkg::*;
#(
    parameter int DATA_WIDTH  = 128,
    parameter int DEPTH       = 32,
    parameter int PROG_THRESH = 16
) (
    input  logic                  ap_clk,
    input  logic                  areset,
    input  logic                  push_vld,
    output logic                  push_rdy,
    input  logic [DATA_WIDTH-1:0] push_dat,
    input  logic                  pop_rdy,
    output logic                  head_vld,
    output logic [DATA_WIDTH-1:0] head_dat,
    output logic                  full,
    output logic                  prog_full,
    output logic                  empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = occ_width(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [OCC_W-1:0]      occ;
    logic [OCC_W-1:0]      occ_nxt;
    logic                  full_q;
    logic                  prog_full_q;
    logic                  empty_q;
    logic                  do_push;
    logic                  do_pop;

    assign do_pop   = pop_rdy && !empty_q;
    assign push_rdy = !full_q || do_pop;
    assign do_push  = push_vld && push_rdy;

    assign head_vld  = !empty_q;
    assign head_dat  = mem[rd_ptr];
    assign full      = full_q;
    assign prog_full = prog_full_q;
    assign empty     = empty_q;

    // Next-state occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        occ_nxt = occ;
        if (do_push && !do_pop) begin
            occ_nxt = occ + OCC_W'(1);
        end else if (do_pop && !do_push) begin
            occ_nxt = occ - OCC_W'(1);
        end
    end

    // Pointers, occupancy and status flags, all registered from next-state occupancy.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occ         <= '0;
            full_q      <= 1'b0;
            prog_full_q <= 1'b0;
            empty_q     <= 1'b1;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            occ         <= occ_nxt;
            full_q      <= (occ_nxt == OCC_W'(DEPTH));
            prog_full_q <= (occ_nxt >= OCC_W'(PROG_THRESH));
            empty_q     <= (occ_nxt == '0);
        end
    end

    // Storage array is never reset; stale entries are unreachable once pointers clear.
    always_ff @(posedge ap_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_dat;
        end
    end

endmodule

// File: rtl/arbiter_1_to_n_request_multicast.sv
// Buffers routed requests and multicasts each one to every port in its destination mask.
// Latency: request valid in cycle 0 -> buffered at edge 2 -> out_valid in cycle 3 on a free port.
// Backpressure: per-port valid/ready; a stalled port holds only its own pending bit, overflow drops and counts.
module arbiter_1_to_n_request_multicast #(
    parameter int NUM_OUT     = 4,
    parameter int DATA_WIDTH  = 128,
    parameter int FIFO_DEPTH  = 32,
    parameter int PROG_THRESH = 16,
    parameter int FORWARD_EN  = 0
) (
    input  logic                          ap_clk,
    input  logic                          areset,
    input  logic                          request_in_valid,
    input  logic [DATA_WIDTH-1:0]         request_in_payload,
    input  logic [NUM_OUT-1:0]            request_in_dest,
    input  logic                          request_in_uplink,
    output logic [NUM_OUT-1:0]            request_out_valid,
    output logic [NUM_OUT*DATA_WIDTH-1:0] request_out_payload,
    input  logic [NUM_OUT-1:0]            request_out_ready,
    output logic                          fifo_prog_full,
    output logic                          fifo_full,
    output logic                          fifo_empty,
    output logic                          fifo_setup_signal,
    output logic [31:0]                   drop_count
);

    import arbiter_1_to_n_request_multicast_pkg::*;

    // Buffered request; its widths follow the module parameters so it lives here.
    typedef struct packed {
        logic [DATA_WIDTH-1:0] payload;
        logic [NUM_OUT-1:0]    dest;
        logic                  uplink;
    } routed_request_t;

    localparam int                 REQ_W       = $bits(routed_request_t);
    localparam bit                 FWD         = (FORWARD_EN != 0);
    localparam logic [NUM_OUT-1:0] UPLINK_MASK = {1'b1, {(NUM_OUT-1){1'b0}}};

    // ---------------- stage 0 ----------------
    logic            s0_vld;
    routed_request_t s0_req;

    // Input valid register; the only stage-0 bit that reset clears.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            s0_vld <= 1'b0;
        end else begin
            s0_vld <= request_in_valid;
        end
    end

    // Input datapath register, qualified by s0_vld so it needs no reset.
    always_ff @(posedge ap_clk) begin
        s0_req.payload <= request_in_payload;
        s0_req.dest    <= request_in_dest;
        s0_req.uplink  <= request_in_uplink;
    end

    // ---------------- stage 1: buffer push / drop ----------------
    logic mask_ok;
    logic push_vld;
    logic push_rdy;
    logic drop_evt;

    // A request with no destination is only routable when it is forwarded to the uplink.
    assign mask_ok  = (s0_req.dest != '0) || (FWD && s0_req.uplink);
    assign push_vld = s0_vld && mask_ok;
    assign drop_evt = s0_vld && !(mask_ok && push_rdy);

    logic             head_vld;
    logic [REQ_W-1:0] head_raw;
    routed_request_t  head_req;
    logic             head_pop;

    fifo_sync_fwft #(
        .DATA_WIDTH (REQ_W),
        .DEPTH      (FIFO_DEPTH),
        .PROG_THRESH(PROG_THRESH)
    ) u_req_fifo (
        .ap_clk   (ap_clk),
        .areset   (areset),
        .push_vld (push_vld),
        .push_rdy (push_rdy),
        .push_dat (s0_req),
        .pop_rdy  (head_pop),
        .head_vld (head_vld),
        .head_dat (head_raw),
        .full     (fifo_full),
        .prog_full(fifo_prog_full),
        .empty    (fifo_empty)
    );

    assign head_req = head_raw;

    // ---------------- head issue / pending mask ----------------
    logic [NUM_OUT-1:0]    head_mask;
    logic [NUM_OUT-1:0]    pending_q;
    logic                  head_loaded;
    logic                  pop_bubble;
    logic                  can_issue;
    logic [NUM_OUT-1:0]    eff_pending;
    logic [NUM_OUT-1:0]    port_free;
    logic [NUM_OUT-1:0]    issue;
    logic [NUM_OUT-1:0]    remaining;
    logic [NUM_OUT-1:0]    out_valid_q;
    logic [DATA_WIDTH-1:0] out_payload_q [NUM_OUT];

    // Uplink traffic goes only to the last port; otherwise the route mask is used as-is.
    assign head_mask = (FWD && head_req.uplink) ? UPLINK_MASK : head_req.dest;

    // A fresh head uses its own mask; a partly issued head uses the saved remainder.
    // The cycle after every pop is a deliberate bubble so issue timing is fixed.
    assign can_issue   = head_vld && !pop_bubble;
    assign eff_pending = head_loaded ? pending_q : head_mask;
    assign port_free   = ~out_valid_q | request_out_ready;
    assign issue       = can_issue ? (eff_pending & port_free) : '0;
    assign remaining   = eff_pending & ~port_free;
    assign head_pop    = can_issue && (remaining == '0);

    // Track which destinations of the current head are still outstanding.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            head_loaded <= 1'b0;
            pending_q   <= '0;
            pop_bubble  <= 1'b0;
        end else begin
            pop_bubble <= head_pop;
            if (head_pop) begin
                head_loaded <= 1'b0;
                pending_q   <= '0;
            end else if (can_issue) begin
                head_loaded <= 1'b1;
                pending_q   <= remaining;
            end
        end
    end

    // Per-port valid: set on issue, cleared on acceptance, otherwise held.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            out_valid_q <= '0;
        end else begin
            for (int i = 0; i < NUM_OUT; i++) begin
                if (issue[i]) begin
                    out_valid_q[i] <= 1'b1;
                end else if (request_out_ready[i]) begin
                    out_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    // Per-port payload register, only written on issue so it is stable while stalled.
    always_ff @(posedge ap_clk) begin
        for (int i = 0; i < NUM_OUT; i++) begin
            if (issue[i]) begin
                out_payload_q[i] <= head_req.payload;
            end
        end
    end

    assign request_out_valid = out_valid_q;

    for (genvar g = 0; g < NUM_OUT; g++) begin : g_out
        assign request_out_payload[g*DATA_WIDTH +: DATA_WIDTH] = out_payload_q[g];
    end

    // ---------------- drop counter ----------------
    logic [DROP_COUNT_WIDTH-1:0] drop_q;

    // Count overflow and unroutable requests, saturating at the maximum.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            drop_q <= '0;
        end else if (drop_evt && (drop_q != DROP_COUNT_MAX)) begin
            drop_q <= drop_q + 32'd1;
        end
    end

    assign drop_count = drop_q;

    // ---------------- setup sequencing ----------------
    setup_state_t setup_state;
    logic         setup_q;

    // Setup flag stays high for two edges after reset is released.
    always_ff @(posedge ap_clk) begin
        if (areset) begin
            setup_state <= SETUP_HOLD;
            setup_q     <= 1'b1;
        end else begin
            case (setup_state)
                SETUP_HOLD: begin
                    setup_state <= SETUP_WAIT;
                    setup_q     <= 1'b1;
                end
                SETUP_WAIT: begin
                    setup_state <= SETUP_DONE;
                    setup_q     <= 1'b0;
                end
                default: begin
                    setup_state <= SETUP_DONE;
                    setup_q     <= 1'b0;
                end
            endcase
        end
    end

    assign fifo_setup_signal = setup_q;

endmodule
